// File: rtl/dma_wb.sv
// Single-channel word-copy DMA engine: Wishbone slave register port plus Wishbone master port.
// Optional build macro DMA_FILL_EN adds the FILL mode (write the SRC value to DST, no reads).
module dma_wb (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [25:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_we_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic [3:0]  wb_sel_i,
    output logic        wb_ack_o,
    output logic        int_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    output logic        wbm_we_o,
    output logic        wbm_stb_o,
    output logic        wbm_cyc_o,
    output logic [3:0]  wbm_sel_o,
    input  logic        wbm_ack_i
);

    typedef enum logic [1:0] {IDLE, RD, WR, GAP} state_t;

    state_t      state;
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] len;
    logic        ie;
    logic        done;
    logic        abort_pend;
    logic        fill;
    logic        fill_nxt;

    logic        busy;
    logic        reg_wr;
    logic        ctrl_wr;
    logic        start_req;
    logic        abort_req;
    logic        finish;
    logic        launch;
    logic        done_nxt;
    logic        ie_nxt;
    logic [31:0] rdata;
    logic        unused_ok;

    assign wbm_sel_o = 4'hf;
    assign unused_ok = &{1'b0, wb_sel_i, wb_adr_i[25:2]};

    always_comb begin
        busy      = (state != IDLE);
        // Register writes commit on the ack cycle, so the new value is visible the cycle after ack.
        reg_wr    = wb_cyc_i & wb_stb_i & wb_we_i & wb_ack_o;
        ctrl_wr   = reg_wr & (wb_adr_i[1:0] == 2'd3);
        start_req = ctrl_wr & wb_dat_i[0] & ~wb_dat_i[1] & ~busy;
        abort_req = abort_pend | (ctrl_wr & wb_dat_i[1]);
        ie_nxt    = ctrl_wr ? wb_dat_i[2] : ie;

        finish = 1'b0;
        case (state)
            IDLE:    finish = start_req & (len == 16'd0);
            RD, WR:  finish = wbm_ack_i & abort_req;
            GAP:     finish = (len == 16'd0) | abort_req;
            default: finish = 1'b0;
        endcase

        launch   = ((state == IDLE) & start_req & (len != 16'd0)) |
                   ((state == GAP) & ~finish);
        // A new completion outranks a DONE clear arriving in the same cycle.
        done_nxt = finish | (done & ~(ctrl_wr & wb_dat_i[3]));

        case (wb_adr_i[1:0])
            2'd0:    rdata = src;
            2'd1:    rdata = dst;
            2'd2:    rdata = {16'h0000, len};
            default: rdata = {27'd0, fill, done, ie, 1'b0, busy};
        endcase
    end

`ifdef DMA_FILL_EN
    assign fill_nxt = (ctrl_wr & ~busy) ? wb_dat_i[4] : fill;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            fill <= 1'b0;
        end else begin
            fill <= fill_nxt;
        end
    end
`else
    assign fill     = 1'b0;
    assign fill_nxt = 1'b0;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state      <= IDLE;
            src        <= 32'd0;
            dst        <= 32'd0;
            len        <= 16'd0;
            ie         <= 1'b0;
            done       <= 1'b0;
            abort_pend <= 1'b0;
            int_o      <= 1'b0;
            wb_ack_o   <= 1'b0;
            wb_dat_o   <= 32'd0;
            wbm_adr_o  <= 32'd0;
            wbm_dat_o  <= 32'd0;
            wbm_we_o   <= 1'b0;
            wbm_stb_o  <= 1'b0;
            wbm_cyc_o  <= 1'b0;
        end else begin
            wb_ack_o <= wb_cyc_i & wb_stb_i & ~wb_ack_o;
            if (wb_cyc_i & wb_stb_i & ~wb_ack_o) begin
                wb_dat_o <= rdata;
            end
            ie    <= ie_nxt;
            done  <= done_nxt;
            int_o <= done_nxt & ie_nxt;

            if (reg_wr & ~busy) begin
                case (wb_adr_i[1:0])
                    2'd0:    src <= {wb_dat_i[31:2], 2'b00};
                    2'd1:    dst <= {wb_dat_i[31:2], 2'b00};
                    2'd2:    len <= wb_dat_i[15:0];
                    default: ;
                endcase
            end

            if (busy & ctrl_wr & wb_dat_i[1]) begin
                abort_pend <= 1'b1;
            end
            if (finish) begin
                abort_pend <= 1'b0;
            end

            if (launch) begin
                wbm_cyc_o <= 1'b1;
                wbm_stb_o <= 1'b1;
                if (fill_nxt) begin
                    state     <= WR;
                    wbm_we_o  <= 1'b1;
                    wbm_adr_o <= dst;
`ifdef DMA_FILL_EN
                    wbm_dat_o <= src;
`endif
                end else begin
                    state     <= RD;
                    wbm_we_o  <= 1'b0;
                    wbm_adr_o <= src;
                end
            end else begin
                case (state)
                    RD: begin
                        if (wbm_ack_i) begin
                            if (abort_req) begin
                                state     <= IDLE;
                                wbm_cyc_o <= 1'b0;
                                wbm_stb_o <= 1'b0;
                            end else begin
                                state     <= WR;
                                wbm_we_o  <= 1'b1;
                                wbm_adr_o <= dst;
                                wbm_dat_o <= wbm_dat_i;
                            end
                        end
                    end
                    WR: begin
                        if (wbm_ack_i) begin
                            dst <= dst + 32'd4;
                            if (!fill) begin
                                src <= src + 32'd4;
                            end
                            if (len != 16'd0) begin
                                len <= len - 16'd1;
                            end
                            wbm_cyc_o <= 1'b0;
                            wbm_stb_o <= 1'b0;
                            wbm_we_o  <= 1'b0;
                            state     <= abort_req ? IDLE : GAP;
                        end
                    end
                    GAP: begin
                        if (finish) begin
                            state <= IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dma_wb.sv
// Bench for dma_wb: register vector table, bus scoreboard, and sequences for abort, busy, fill and reset.
module tb_dma_wb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [25:0] wb_adr = '0;
    logic [31:0] wb_dat = '0;
    logic [31:0] wb_dat_o;
    logic        wb_we = 1'b0, wb_stb = 1'b0, wb_cyc = 1'b0;
    logic        wb_ack_o, int_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic [31:0] wbm_dat_i = '0;
    logic        wbm_we_o, wbm_stb_o, wbm_cyc_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_ack_i = 1'b0;

    always #5 clk = ~clk;

    dma_wb dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(wb_adr), .wb_dat_i(wb_dat),
        .wb_dat_o(wb_dat_o), .wb_we_i(wb_we), .wb_stb_i(wb_stb), .wb_cyc_i(wb_cyc),
        .wb_sel_i(4'hf), .wb_ack_o(wb_ack_o), .int_o(int_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
        .wbm_we_o(wbm_we_o), .wbm_stb_o(wbm_stb_o), .wbm_cyc_o(wbm_cyc_o),
        .wbm_sel_o(wbm_sel_o), .wbm_ack_i(wbm_ack_i)
    );

`ifdef DMA_FILL_EN
    localparam bit FILL_EN = 1'b1;
`else
    localparam bit FILL_EN = 1'b0;
`endif

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } bus_t;

    typedef struct {
        logic [1:0]  adr;
        logic [31:0] wdat;
        logic [31:0] rexp;
        string       name;
    } vec_t;

    bus_t        exp_q[$];
    logic [31:0] mem [logic [31:0]];
    int          checks = 0;
    int          errors = 0;
    int          rd_lat = 0;
    int          wr_lat = 0;
    int          cnt = 0;
    bit          cyc_seen = 1'b0;
    bit          gap_pend = 1'b0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'h0;
    endfunction

    // Memory slave with programmable read/write wait states.
    always @(posedge clk) begin
        if (rst) begin
            wbm_ack_i <= 1'b0;
            cnt       <= 0;
        end else if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i) begin
            if (cnt >= (wbm_we_o ? wr_lat : rd_lat)) begin
                wbm_ack_i <= 1'b1;
                cnt       <= 0;
                if (!wbm_we_o) wbm_dat_i <= mem_rd(wbm_adr_o);
            end else begin
                cnt <= cnt + 1;
            end
        end else begin
            wbm_ack_i <= 1'b0;
            cnt       <= 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic monitor();
        bus_t e;
        forever begin
            @(negedge clk);
            if (gap_pend) begin
                check("gap_cyc_low", {31'd0, wbm_cyc_o}, 32'd0);
                gap_pend = 1'b0;
            end
            if (wbm_cyc_o) cyc_seen = 1'b1;
            if (wbm_cyc_o && wbm_stb_o && wbm_ack_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL bus_unexpected: got we=%0b adr=%h expected no cycle", wbm_we_o, wbm_adr_o);
                end else begin
                    e = exp_q.pop_front();
                    check("bus_we", {31'd0, wbm_we_o}, {31'd0, e.we});
                    check("bus_adr", wbm_adr_o, e.adr);
                    if (e.we) begin
                        check("bus_wdat", wbm_dat_o, e.dat);
                        mem[wbm_adr_o] = wbm_dat_o;
                        gap_pend = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic wb_xfer(input logic we, input logic [1:0] a, input logic [31:0] d,
                           output logic [31:0] q);
        int n;
        n = 0;
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = {24'd0, a}; wb_dat = d;
        @(negedge clk);
        while (!wb_ack_o && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (!wb_ack_o) begin
            checks++;
            errors++;
            $display("FAIL wb_ack_timeout: got no ack expected ack within 8 cycles");
        end
        q = wb_dat_o;
        @(posedge clk);
        #1;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        logic [31:0] q;
        wb_xfer(1'b1, a, d, q);
    endtask

    task automatic chk_reg(input string name, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] q;
        wb_xfer(1'b0, a, 32'd0, q);
        check(name, q, exp);
    endtask

    task automatic wait_int(input string name, input int bound, output int n);
        n = 0;
        while (!int_o && n < bound) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, int_o}, 32'd1);
    endtask

    task automatic wait_we(input string name);
        int n;
        n = 0;
        while (!wbm_we_o && n < 30) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, wbm_we_o}, 32'd1);
    endtask

    task automatic push(input logic we, input logic [31:0] a, input logic [31:0] d);
        bus_t e;
        e.we = we; e.adr = a; e.dat = d;
        exp_q.push_back(e);
    endtask

    initial begin
        vec_t        vecs[7];
        int          n;
        logic [31:0] a;

        vecs[0] = '{2'd0, 32'h1234_5677, 32'h1234_5674, "src_mask"};
        vecs[1] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, "dst_mask"};
        vecs[2] = '{2'd2, 32'hABCD_1234, 32'h0000_1234, "len_hi_zero"};
        vecs[3] = '{2'd3, 32'h0000_0004, 32'h0000_0004, "ctrl_ie"};
        vecs[4] = '{2'd3, 32'h0000_0010, FILL_EN ? 32'h10 : 32'h0, "ctrl_fill"};
        vecs[5] = '{2'd3, 32'h0000_0008, 32'h0000_0000, "ctrl_done_clr"};
        vecs[6] = '{2'd0, 32'h0000_0000, 32'h0000_0000, "src_zero"};

        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_wb_ack", {31'd0, wb_ack_o}, 32'd0);
        check("rst_wb_dat", wb_dat_o, 32'd0);
        check("rst_int", {31'd0, int_o}, 32'd0);
        check("rst_wbm_ctl", {29'd0, wbm_cyc_o, wbm_stb_o, wbm_we_o}, 32'd0);
        check("rst_wbm_adr", wbm_adr_o, 32'd0);
        check("rst_wbm_dat", wbm_dat_o, 32'd0);
        check("wbm_sel", {28'd0, wbm_sel_o}, 32'hf);
        rst = 1'b0;
        for (int r = 0; r < 4; r++) chk_reg("rst_reg", 2'(r), 32'd0);

        // Register write/readback vectors while idle
        for (int i = 0; i < 7; i++) begin
            wr(vecs[i].adr, vecs[i].wdat);
            chk_reg(vecs[i].name, vecs[i].adr, vecs[i].rexp);
        end

        // Copy test
        for (int i = 0; i < 4; i++) begin
            a = 32'h4000_0000 + 32'(4 * i);
            mem[a] = 32'(8'h11 * (i + 1));
            push(1'b0, a, 32'd0);
            push(1'b1, 32'h2000_0100 + 32'(4 * i), 32'(8'h11 * (i + 1)));
        end
        wr(2'd0, 32'h4000_0000);
        wr(2'd1, 32'h2000_0100);
        wr(2'd2, 32'd4);
        cyc_seen = 1'b0;
        wr(2'd3, 32'h5);
        check("copy_cyc_start", {31'd0, wbm_cyc_o}, 32'd1);
        wait_int("copy_int", 300, n);
        check("copy_cycles", n, 32'd21);
        check("copy_q_empty", exp_q.size(), 32'd0);
        check("copy_dst0", mem_rd(32'h2000_0100), 32'h11);
        check("copy_dst3", mem_rd(32'h2000_010C), 32'h44);
        chk_reg("copy_len", 2'd2, 32'd0);
        chk_reg("copy_src", 2'd0, 32'h4000_0010);
        chk_reg("copy_dst", 2'd1, 32'h2000_0110);
        chk_reg("copy_ctrl", 2'd3, 32'hC);

        // Abort while a read is stalled
        rd_lat = 5;
        wr(2'd3, 32'hC);
        wr(2'd1, 32'h2000_0200);
        wr(2'd2, 32'd100);
        wr(2'd0, 32'h4000_0000);
        push(1'b0, 32'h4000_0000, 32'd0);
        wr(2'd3, 32'h5);
        wr(2'd3, 32'h6);
        check("abort_rd_stb_held", {31'd0, wbm_stb_o}, 32'd1);
        wait_int("abort_rd_int", 100, n);
        repeat (3) @(negedge clk);
        check("abort_rd_q_empty", exp_q.size(), 32'd0);
        chk_reg("abort_rd_len", 2'd2, 32'd100);
        chk_reg("abort_rd_src", 2'd0, 32'h4000_0000);
        chk_reg("abort_rd_dst", 2'd1, 32'h2000_0200);
        chk_reg("abort_rd_ctrl", 2'd3, 32'hC);

        // Abort while a write is stalled: the write still counts
        rd_lat = 0;
        wr_lat = 6;
        wr(2'd3, 32'hC);
        wr(2'd2, 32'd50);
        push(1'b0, 32'h4000_0000, 32'd0);
        push(1'b1, 32'h2000_0200, 32'h11);
        wr(2'd3, 32'h5);
        wait_we("abort_wr_reach_wr");
        wr(2'd3, 32'h6);
        wait_int("abort_wr_int", 100, n);
        wr_lat = 0;
        check("abort_wr_q_empty", exp_q.size(), 32'd0);
        chk_reg("abort_wr_len", 2'd2, 32'd49);
        chk_reg("abort_wr_src", 2'd0, 32'h4000_0004);
        chk_reg("abort_wr_dst", 2'd1, 32'h2000_0204);
        chk_reg("abort_wr_ctrl", 2'd3, 32'hC);

        // START together with ABORT starts nothing
        wr(2'd3, 32'hC);
        cyc_seen = 1'b0;
        wr(2'd3, 32'h7);
        repeat (10) @(negedge clk);
        check("start_abort_no_cyc", {31'd0, cyc_seen}, 32'd0);
        chk_reg("start_abort_ctrl", 2'd3, 32'h4);

        // LEN=0 with START, then DONE set/clear in the same write
        wr(2'd2, 32'd0);
        cyc_seen = 1'b0;
        wr(2'd3, 32'h5);
        check("len0_int_next", {31'd0, int_o}, 32'd1);
        chk_reg("len0_ctrl", 2'd3, 32'hC);
        check("len0_no_cyc", {31'd0, cyc_seen}, 32'd0);
        wr(2'd3, 32'hC);
        check("len0_clr_int", {31'd0, int_o}, 32'd0);
        wr(2'd3, 32'hD);
        chk_reg("done_set_wins", 2'd3, 32'hC);

        // Writes while BUSY are ignored
        wr(2'd3, 32'hC);
        for (int i = 0; i < 8; i++) begin
            a = 32'h4000_1000 + 32'(4 * i);
            mem[a] = 32'hA500_0000 + 32'(i);
            push(1'b0, a, 32'd0);
            push(1'b1, 32'h2000_0300 + 32'(4 * i), 32'hA500_0000 + 32'(i));
        end
        wr(2'd0, 32'h4000_1000);
        wr(2'd1, 32'h2000_0300);
        wr(2'd2, 32'd8);
        wr(2'd3, 32'h5);
        wr(2'd0, 32'h0);
        wr(2'd2, 32'd3);
        wait_int("busy_int", 400, n);
        check("busy_q_empty", exp_q.size(), 32'd0);
        chk_reg("busy_src", 2'd0, 32'h4000_1020);
        chk_reg("busy_dst", 2'd1, 32'h2000_0320);
        chk_reg("busy_len", 2'd2, 32'd0);
        wr(2'd3, 32'hC);
        check("clr_int_drop", {31'd0, int_o}, 32'd0);
        chk_reg("clr_ctrl", 2'd3, 32'h4);

`ifdef DMA_FILL_EN
        // Fill: writes of the SRC value, no reads, SRC unchanged
        wr(2'd3, 32'h14);
        wr(2'd0, 32'hDEAD_BEEF);
        wr(2'd1, 32'h2000_0000);
        wr(2'd2, 32'd3);
        for (int i = 0; i < 3; i++) push(1'b1, 32'h2000_0000 + 32'(4 * i), 32'hDEAD_BEEC);
        wr(2'd3, 32'h15);
        wait_int("fill_int", 100, n);
        check("fill_cycles", n, 32'd10);
        check("fill_q_empty", exp_q.size(), 32'd0);
        chk_reg("fill_src", 2'd0, 32'hDEAD_BEEC);
        chk_reg("fill_len", 2'd2, 32'd0);
        wr(2'd3, 32'hC);
`endif

        // Reset in WR with the write ack withheld
        wr_lat = 1000;
        wr(2'd0, 32'h4000_0000);
        wr(2'd1, 32'h2000_0400);
        wr(2'd2, 32'd5);
        push(1'b0, 32'h4000_0000, 32'd0);
        push(1'b1, 32'h2000_0400, 32'h11);
        wr(2'd3, 32'h5);
        wait_we("rst_reach_wr");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_drops_cyc", {30'd0, wbm_cyc_o, wbm_stb_o}, 32'd0);
        repeat (2) @(negedge clk);
        exp_q.delete();
        wr_lat = 0;
        rst = 1'b0;
        for (int r = 0; r < 4; r++) chk_reg("post_rst_reg", 2'(r), 32'd0);
        check("post_rst_int", {31'd0, int_o}, 32'd0);
        check("post_rst_we", {31'd0, wbm_we_o}, 32'd0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
